pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

- Central hazard and stall sequencer for the five-stage pipeline.
- Drives the per-stage hold and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Handles load-use interlocks, taken-branch squashes, multi-cycle data-memory waits with a timeout fault, and program halt/resume.
- Sits beside the datapath; all its outputs feed register enables and clears directly.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive mem_busy cycles tolerated before fault; legal range 1..255.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- ex_mtr  in  1  instruction in EX is a load (memory-to-register).
- ex_rd  in  5  destination register of the instruction in EX.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_busy  in  1  data memory is not ready this cycle.
- wb_halt  in  1  instruction in WB is a halt syscall.
- resume  in  1  single-cycle pulse that releases halt.
- stall_pc, stall_ifid, stall_idex, stall_exmem  out  1 each  1 = hold the register.
- flush_ifid, flush_idex, flush_memwb  out  1 each  1 = load a zero bubble.
- halted  out  1  controller is in HALT.
- fault  out  1  memory timeout occurred; sticky.

## Operation
- FSM states: RUN, MWAIT, HALT, FAULT. Reset state is RUN and the wait counter is 0.
- While rst is low, every output is 0.
- Outputs are a Mealy function of state and current inputs. Priority within a cycle: wb_halt > mem_busy > branch_taken > load-use.
- **RUN, wb_halt=1:** stall_pc, stall_ifid, stall_idex and stall_exmem = 1; flush_memwb = 1. Next state HALT.
- **RUN, mem_busy=1:** same stall and flush outputs as wb_halt. Wait counter := 1. Next state MWAIT.
- **RUN, branch_taken=1:** flush_ifid = 1 and flush_idex = 1; no stalls. A coincident load-use hazard is ignored.
- **RUN, load-use:** the hazard condition is ex_mtr && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)). Response: stall_pc = 1, stall_ifid = 1, flush_idex = 1. Stay in RUN.
- **MWAIT, mem_busy=1:**
  - Outputs are the same as the RUN mem_busy case.
  - If counter < MEM_TIMEOUT: counter increments.
  - If counter == MEM_TIMEOUT: next state FAULT.
- **MWAIT, mem_busy=0:** outputs are evaluated exactly as in RUN, with branch and load-use still honoured. Counter := 0. Next state RUN.
- **HALT:** all four stalls = 1, flush_memwb = 1, halted = 1. On resume=1, outputs are RUN-equivalent that cycle and the next state is RUN. wb_halt is ignored in HALT.
- **FAULT:** all four stalls = 1, flush_memwb = 1, fault = 1. Only reset exits FAULT.
- Reset mid-operation, in any state: asynchronous return to RUN, counter cleared.

## Timing
- Hazard responses are combinational: they take effect in the same cycle as the triggering inputs, with zero latency.
- A mem_busy of N cycles, N ≤ MEM_TIMEOUT, produces exactly N stall cycles.
- mem_busy held for MEM_TIMEOUT+1 consecutive cycles asserts fault in the following cycle.
- halted rises one cycle after wb_halt is sampled and falls one cycle after resume is sampled.

## Configuration
- PIPE_STALL_CNT_EN:
  - Defined: adds output port stall_cnt (out, 32). It counts cycles with stall_pc=1 and rst high, saturates at 32'hFFFFFFFF, and resets to 0.
  - Undefined: the port and counter are absent. All other behaviour is unchanged.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN=2'd0, MWAIT=2'd1, HALT=2'd2, FAULT=2'd3);
  - REG_ZERO = 5'd0;
  - the register-number width constant REG_W = 5.
- One sub-module, pipeline_loaduse_detect: purely combinational load-use comparator, one bit out.
- The FSM and wait counter (width $clog2(MEM_TIMEOUT+1)) live in the top module.

## Test plan
- **Load-use:** ex_mtr=1, ex_rd=8, id_uses_rt=1, id_rt=8 -> stall_pc=stall_ifid=flush_idex=1 for one cycle. With ex_rd=0 -> no stall.
- **Branch plus load-use together:** branch_taken=1 with the load-use above -> flush_ifid=flush_idex=1, stall_pc=0.
- **Memory wait:** mem_busy for 3 cycles with MEM_TIMEOUT=15 -> exactly 3 cycles of stalls plus flush_memwb, back to RUN, fault=0.
- **Timeout:** mem_busy held 17 cycles with MEM_TIMEOUT=15 -> fault=1 from cycle 17, sticky after mem_busy drops; rst low clears it.
- **Halt/resume:** wb_halt=1 for one cycle -> halted=1 next cycle with full stall; resume pulse 5 cycles later -> halted=0 next cycle.
- **Stall counter** (PIPE_STALL_CNT_EN defined): run the load-use case plus the 3-cycle wait -> stall_cnt=4; asserting rst mid-count -> 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
package pipeline_ctrl_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MWAIT = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } state_e;

   typedef struct packed {
      logic stall_pc;
      logic stall_ifid;
      logic stall_idex;
      logic stall_exmem;
      logic flush_ifid;
      logic flush_idex;
      logic flush_memwb;
   } ctrl_t;

   // Freeze every stage and drain a bubble into WB.
   function automatic ctrl_t full_stall();
      ctrl_t c;
      c = '0;
      c.stall_pc    = 1'b1;
      c.stall_ifid  = 1'b1;
      c.stall_idex  = 1'b1;
      c.stall_exmem = 1'b1;
      c.flush_memwb = 1'b1;
      return c;
   endfunction
endpackage

// File: rtl/pipeline_loaduse_detect.sv
// rtl/pipeline_loaduse_detect.sv - combinational load-use hazard comparator
module pipeline_loaduse_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic             ex_mtr,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   output logic             hazard
);
   assign hazard = ex_mtr && (ex_rd != REG_ZERO) &&
                   ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - hazard/stall sequencer for the five-stage pipeline
// Optional PIPE_STALL_CNT_EN adds a saturating stall_cnt output.
module pipeline_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mtr,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             branch_taken,
   input  logic             mem_busy,
   input  logic             wb_halt,
   input  logic             resume,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             stall_idex,
   output logic             stall_exmem,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_memwb,
   output logic             halted,
   output logic             fault
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             load_use;
   logic             halt_req;
   logic             halted_c, fault_c;
   ctrl_t            run_ctrl, ctrl;

   pipeline_loaduse_detect u_loaduse (
      .ex_mtr     (ex_mtr),
      .ex_rd      (ex_rd),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .hazard     (load_use)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            if (wb_halt) begin
               state_d = HALT;
            end else if (mem_busy) begin
               state_d    = MWAIT;
               wait_cnt_d = CNT_W'(1);
            end
         end
         MWAIT: begin
            if (mem_busy) begin
               if (wait_cnt_q < CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_W'(1);
               else                      state_d    = FAULT;
            end else begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end
         end
         HALT:    if (resume) state_d = RUN;
         FAULT:   state_d = FAULT;
         default: state_d = RUN;
      endcase
   end

   // Normal-operation response; a halt request is not re-armed while already halted.
   always_comb begin
      halt_req = wb_halt && (state_q != HALT);
      run_ctrl = '0;
      if (halt_req || mem_busy) begin
         run_ctrl = full_stall();
      end else if (branch_taken) begin
         run_ctrl.flush_ifid = 1'b1;
         run_ctrl.flush_idex = 1'b1;
      end else if (load_use) begin
         run_ctrl.stall_pc   = 1'b1;
         run_ctrl.stall_ifid = 1'b1;
         run_ctrl.flush_idex = 1'b1;
      end
   end

   always_comb begin
      ctrl     = '0;
      halted_c = 1'b0;
      fault_c  = 1'b0;
      case (state_q)
         RUN, MWAIT: ctrl = run_ctrl;
         HALT: begin
            ctrl     = resume ? run_ctrl : full_stall();
            halted_c = 1'b1;
         end
         FAULT: begin
            ctrl    = full_stall();
            fault_c = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   assign stall_pc    = rst & ctrl.stall_pc;
   assign stall_ifid  = rst & ctrl.stall_ifid;
   assign stall_idex  = rst & ctrl.stall_idex;
   assign stall_exmem = rst & ctrl.stall_exmem;
   assign flush_ifid  = rst & ctrl.flush_ifid;
   assign flush_idex  = rst & ctrl.flush_idex;
   assign flush_memwb = rst & ctrl.flush_memwb;
   assign halted      = rst & halted_c;
   assign fault       = rst & fault_c;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif
endmodule
